apb_uart_rx_ctrl: RTL and testbench

APB-style register controller that configures and services the UART receive datapath (`rcv_block`). It holds the runtime configuration, `bit_period` and `data_size`, and exposes receiver status and data to a bus master. It turns bus reads into the one-cycle `data_read` acknowledge the receiver's data buffer requires. Errors are latched into sticky registers so short receiver error pulses are never missed.

---
 rtl/apb_uart_rx_ctrl_pkg.sv | 32 +++
 rtl/apb_uart_rx_ctrl_if.sv | 22 ++
 rtl/apb_uart_rx_ctrl_fsm.sv | 39 +++
 rtl/apb_uart_rx_ctrl.sv | 122 ++++++++++++
 tb/tb_apb_uart_rx_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller: register map, bus FSM
// states and the configuration helpers used by the register decode.
package uart_ctrl_pkg;

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_ERROR  = 3'd1;
    localparam logic [2:0] ADDR_BP_LO  = 3'd2;
    localparam logic [2:0] ADDR_BP_HI  = 3'd3;
    localparam logic [2:0] ADDR_DSIZE  = 3'd4;
    localparam logic [2:0] ADDR_DATA   = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } bus_state_t;

    // The receiver only supports 5, 7 and 8 data bits; checked on the full
    // written byte so stray high bits are rejected too.
    function automatic logic ds_legal(input logic [7:0] value);
        return (value == 8'd5) || (value == 8'd7) || (value == 8'd8);
    endfunction

    function automatic logic [7:0] data_mask(input logic [3:0] ds);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i < int'(ds));
        end
        return m;
    endfunction

endpackage

// File: rtl/apb_uart_rx_ctrl_if.sv
// APB-style slave bus between a master and the UART receive controller.
interface apb_uart_rx_ctrl_if;

    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pslverr
    );

endinterface

// File: rtl/apb_uart_rx_ctrl_fsm.sv
// Bus phase tracker: follows IDLE/SETUP/ACCESS and produces the strobes the
// register file uses to capture a request and commit its side effects.
module apb_bus_fsm
    import uart_ctrl_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic psel,
    input  logic penable,
    output logic capture,
    output logic access,
    output logic access_first
);

    bus_state_t state, state_next;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        // NOTE: state registers use <= so every flop samples pre-edge values.
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default first so no path through the case infers a latch.
        state_next = IDLE;
        unique case (state)
            IDLE:    state_next = (psel && !penable) ? SETUP  : IDLE;
            SETUP:   state_next = (psel &&  penable) ? ACCESS : IDLE;
            ACCESS:  state_next = (psel && !penable) ? SETUP  : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign capture      = (state == SETUP) && psel && penable;
    assign access       = (state == ACCESS);
    // ACCESS never lasts more than one cycle, so its first cycle is all of it.
    assign access_first = access;

endmodule

// File: rtl/apb_uart_rx_ctrl.sv
// Register controller for the UART receive datapath: holds bit_period and
// data_size, reports status/data, latches sticky errors, acks buffer reads.
module apb_uart_rx_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter logic [13:0] BP_RESET = 14'd10,
    parameter logic [3:0]  DS_RESET = 4'd8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    apb_uart_rx_ctrl_if.slave    bus,
    input  logic [7:0]           rx_data,
    input  logic                 data_ready,
    input  logic                 overrun_error,
    input  logic                 framing_error,
    output logic                 data_read,
    output logic [13:0]          bit_period,
    output logic [3:0]           data_size
);

    logic       capture, access, access_first;
    logic       req_write;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       sticky_frm, sticky_ovr;

    logic [7:0] rd_data;
    logic       dec_err, wr_bp_lo, wr_bp_hi, wr_ds, rd_error, rd_data_ack;

    apb_bus_fsm u_fsm (
        .clk          (clk),
        .n_rst        (n_rst),
        .psel         (bus.psel),
        .penable      (bus.penable),
        .capture      (capture),
        .access       (access),
        .access_first (access_first)
    );

    // The request is frozen when the access phase is confirmed, so decode in
    // ACCESS does not depend on what the master drives during that cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (capture) begin
            req_write <= bus.pwrite;
            req_addr  <= bus.paddr;
            req_wdata <= bus.pwdata;
        end
    end

    always_comb begin
        rd_data     = '0;
        dec_err     = 1'b0;
        wr_bp_lo    = 1'b0;
        wr_bp_hi    = 1'b0;
        wr_ds       = 1'b0;
        rd_error    = 1'b0;
        rd_data_ack = 1'b0;
        unique case (req_addr)
            ADDR_STATUS: if (req_write) dec_err = 1'b1;
                         else           rd_data = {7'b0, data_ready};
            ADDR_ERROR: begin
                if (req_write) dec_err = 1'b1;
                else begin
                    rd_data  = {6'b0, sticky_ovr, sticky_frm};
                    rd_error = 1'b1;
                end
            end
            ADDR_BP_LO: if (req_write) wr_bp_lo = 1'b1;
                        else           rd_data  = bit_period[7:0];
            ADDR_BP_HI: if (req_write) wr_bp_hi = 1'b1;
                        else           rd_data  = {2'b00, bit_period[13:8]};
            ADDR_DSIZE: begin
                if (!req_write)               rd_data = {4'b0, data_size};
                else if (ds_legal(req_wdata)) wr_ds   = 1'b1;
                else                          dec_err = 1'b1;
            end
            ADDR_DATA: begin
                if (req_write) dec_err = 1'b1;
                else if (data_ready) begin
                    rd_data     = rx_data & data_mask(data_size);
                    rd_data_ack = 1'b1;
                end
            end
            default: dec_err = 1'b1;
        endcase
    end

    assign bus.prdata  = access ? rd_data : 8'h00;
    assign bus.pslverr = access ? dec_err : 1'b0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_period <= BP_RESET;
            data_size  <= DS_RESET;
        end else if (access_first) begin
            if (wr_bp_lo) bit_period[7:0]  <= req_wdata;
            if (wr_bp_hi) bit_period[13:8] <= req_wdata[5:0];
            if (wr_ds)    data_size        <= req_wdata[3:0];
        end
    end

    // Set beats clear: an error present during the clearing read survives it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sticky_frm <= 1'b0;
            sticky_ovr <= 1'b0;
        end else begin
            sticky_frm <= (sticky_frm & ~(access_first & rd_error)) | framing_error;
            sticky_ovr <= (sticky_ovr & ~(access_first & rd_error)) | overrun_error;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) data_read <= 1'b0;
        else        data_read <= access_first & rd_data_ack;
    end

endmodule

// File: tb/tb_apb_uart_rx_ctrl.sv
// Self-checking bench for apb_uart_rx_ctrl: table-driven register transfers
// with a response scoreboard, plus hand-written multi-cycle corner cases.
module tb_apb_uart_rx_ctrl;
    import uart_ctrl_pkg::*;

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] rx;
        logic       dr;
        logic [7:0] exp_rdata;
        logic       exp_err;
        logic       exp_dr;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        data_ready = 1'b0;
    logic        overrun_error = 1'b0;
    logic        framing_error = 1'b0;
    logic        data_read;
    logic [13:0] bit_period;
    logic [3:0]  data_size;

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];
    vec_t tbl[22];

    apb_uart_rx_ctrl_if bus ();

    apb_uart_rx_ctrl dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .bus           (bus.slave),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error),
        .data_read     (data_read),
        .bit_period    (bit_period),
        .data_size     (data_size)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                                input logic [7:0] rx, input logic dr, input logic [7:0] exp_rdata,
                                input logic exp_err, input logic exp_dr);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.rx = rx; v.dr = dr;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_dr = exp_dr;
        return v;
    endfunction

    // Full transfer: expectation queued at drive time, popped at the ACCESS sample.
    task automatic xfer(input string name, input vec_t v);
        exp_t e;
        rx_data     = v.rx;
        data_ready  = v.dr;
        exp_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = v.wr;
        bus.paddr   = v.addr;
        bus.pwdata  = v.wdata;
        tick();
        bus.penable = 1'b1;
        tick();
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({name, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({name, "_prdata"}, {24'b0, bus.prdata}, {24'b0, e.rdata});
            check({name, "_pslverr"}, {31'b0, bus.pslverr}, {31'b0, e.err});
        end
        tick();
        @(negedge clk);
        check({name, "_data_read"}, {31'b0, data_read}, {31'b0, v.exp_dr});
        tick();
        @(negedge clk);
        check({name, "_data_read_end"}, {31'b0, data_read}, 32'd0);
        tick();
    endtask

    initial begin
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 3'd0;
        bus.pwdata  = 8'h00;

        //           wr    addr         wdata  rx     dr    exp    err   dr_pulse
        tbl[0]  = mk(1'b0, ADDR_BP_LO,  8'h00, 8'h00, 1'b0, 8'h0A, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, ADDR_BP_HI,  8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, ADDR_DSIZE,  8'h00, 8'h00, 1'b0, 8'h08, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, ADDR_BP_LO,  8'h34, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, ADDR_BP_HI,  8'hC2, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, ADDR_BP_HI,  8'h00, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, ADDR_BP_LO,  8'h00, 8'h00, 1'b0, 8'h34, 1'b0, 1'b0);
        tbl[7]  = mk(1'b1, ADDR_DSIZE,  8'h06, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        tbl[8]  = mk(1'b0, ADDR_DSIZE,  8'h00, 8'h00, 1'b0, 8'h08, 1'b0, 1'b0);
        tbl[9]  = mk(1'b1, ADDR_DSIZE,  8'h05, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, ADDR_DATA,   8'h00, 8'hFF, 1'b1, 8'h1F, 1'b0, 1'b1);
        tbl[11] = mk(1'b0, ADDR_STATUS, 8'h00, 8'hFF, 1'b1, 8'h01, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, ADDR_DATA,   8'h00, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[13] = mk(1'b1, ADDR_DATA,   8'h12, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        tbl[14] = mk(1'b0, 3'd7,        8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        tbl[15] = mk(1'b1, 3'd5,        8'h44, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        tbl[16] = mk(1'b1, ADDR_STATUS, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        tbl[17] = mk(1'b1, ADDR_DSIZE,  8'h07, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[18] = mk(1'b0, ADDR_DATA,   8'h00, 8'hA5, 1'b1, 8'h25, 1'b0, 1'b1);
        tbl[19] = mk(1'b1, ADDR_DSIZE,  8'h08, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[20] = mk(1'b0, ADDR_DATA,   8'h00, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b1);
        tbl[21] = mk(1'b1, ADDR_ERROR,  8'h03, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_bit_period", {18'b0, bit_period}, 32'd10);
        check("rst_data_size", {28'b0, data_size}, 32'd8);
        check("rst_data_read", {31'b0, data_read}, 32'd0);
        check("rst_prdata", {24'b0, bus.prdata}, 32'd0);
        check("rst_pslverr", {31'b0, bus.pslverr}, 32'd0);
        tick();

        for (int i = 0; i < 22; i++) begin
            xfer($sformatf("row%0d", i), tbl[i]);
            if (i == 4) check("bp_after_hi", {18'b0, bit_period}, 32'h0234);
            if (i == 7) check("ds_kept", {28'b0, data_size}, 32'd8);
            if (i == 9) check("ds_five", {28'b0, data_size}, 32'd5);
        end

        // Write visibility: old value during ACCESS, new value the cycle after
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = ADDR_BP_LO; bus.pwdata = 8'h77;
        tick();
        bus.penable = 1'b1;
        tick();
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clk);
        check("wr_vis_before", {18'b0, bit_period}, 32'h0234);
        tick();
        @(negedge clk);
        check("wr_vis_after", {18'b0, bit_period}, 32'h0277);
        tick();

        // Back-to-back DATA reads: ACCESS goes straight into the next SETUP
        rx_data = 8'h3C; data_ready = 1'b1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = ADDR_DATA;
        tick();
        bus.penable = 1'b1;
        tick();
        bus.penable = 1'b0;
        @(negedge clk);
        check("b2b_prdata1", {24'b0, bus.prdata}, 32'h3C);
        tick();
        bus.penable = 1'b1;
        @(negedge clk);
        check("b2b_dr1", {31'b0, data_read}, 32'd1);
        check("b2b_setup_prdata", {24'b0, bus.prdata}, 32'd0);
        tick();
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clk);
        check("b2b_dr_gap", {31'b0, data_read}, 32'd0);
        check("b2b_prdata2", {24'b0, bus.prdata}, 32'h3C);
        tick();
        @(negedge clk);
        check("b2b_dr2", {31'b0, data_read}, 32'd1);
        tick();
        @(negedge clk);
        check("b2b_dr_end", {31'b0, data_read}, 32'd0);
        data_ready = 1'b0;
        tick();

        // penable without a preceding SETUP is ignored
        bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1;
        bus.paddr = ADDR_BP_LO; bus.pwdata = 8'h99;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            check($sformatf("nosetup_prdata%0d", c), {24'b0, bus.prdata}, 32'd0);
            check($sformatf("nosetup_pslverr%0d", c), {31'b0, bus.pslverr}, 32'd0);
        end
        bus.psel = 1'b0; bus.penable = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("nosetup_bp", {18'b0, bit_period}, 32'h0277);
        tick();

        // Sticky framing: one-cycle pulse, read once, then cleared
        framing_error = 1'b1;
        tick();
        framing_error = 1'b0;
        xfer("err_frm1", mk(1'b0, ADDR_ERROR, 8'h00, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0));
        xfer("err_frm2", mk(1'b0, ADDR_ERROR, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));

        // Sticky overrun held across the clearing read: set wins
        overrun_error = 1'b1;
        tick();
        xfer("err_ovr1", mk(1'b0, ADDR_ERROR, 8'h00, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0));
        xfer("err_ovr2", mk(1'b0, ADDR_ERROR, 8'h00, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0));
        overrun_error = 1'b0;
        tick();
        xfer("err_ovr3", mk(1'b0, ADDR_ERROR, 8'h00, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0));
        xfer("err_ovr4", mk(1'b0, ADDR_ERROR, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));

        // Reset during the SETUP phase of a BP_LO write
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = ADDR_BP_LO; bus.pwdata = 8'h55;
        tick();
        n_rst = 1'b0;
        bus.penable = 1'b1;
        @(negedge clk);
        check("rstw_bp", {18'b0, bit_period}, 32'd10);
        check("rstw_ds", {28'b0, data_size}, 32'd8);
        tick();
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rstw_bp_after", {18'b0, bit_period}, 32'd10);
        check("rstw_pslverr", {31'b0, bus.pslverr}, 32'd0);
        tick();

        // Reset during the ACCESS of a DATA read: no acknowledge pulse
        rx_data = 8'h81; data_ready = 1'b1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = ADDR_DATA;
        tick();
        bus.penable = 1'b1;
        tick();
        n_rst = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clk);
        check("rstr_prdata", {24'b0, bus.prdata}, 32'd0);
        check("rstr_dr0", {31'b0, data_read}, 32'd0);
        tick();
        @(negedge clk);
        check("rstr_dr1", {31'b0, data_read}, 32'd0);
        n_rst = 1'b1;
        tick();
        @(negedge clk);
        check("rstr_dr2", {31'b0, data_read}, 32'd0);
        data_ready = 1'b0;

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
